ram_loader: RTL
===============

# ram_loader

Boot-time program loader sitting directly upstream of the 16-byte RAM. It accepts a byte stream over a valid/ready handshake and writes it into consecutive RAM addresses from 0 by driving the RAM's address, control and bidirectional bus pins. It then optionally reads the image back and checks an 8-bit additive checksum. It holds the CPU halted until a load completes cleanly, then releases the RAM pins (hi-Z/low) to the rest of the machine.

## Interface
- DATA_W, 8, RAM word width
- ADDR_W, 4, RAM address width (depth 2^ADDR_W = 16)
- VERIFY, 1, 1 = read-back checksum pass after write; 0 = go straight to DONE

- clk  in  1  system clock, all state on posedge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- start  in  1  single-cycle request to begin a load; honoured in IDLE, DONE, ERROR
- abort  in  1  synchronous abort to IDLE; highest priority
- last_addr  in  ADDR_W  final address to load; sampled on accepted start; N = last_addr+1 bytes
- in_data  in  DATA_W  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept (high only in WRITE)
- ram_bus  inout  DATA_W  RAM data bus; driven only while ram_wa=1, else hi-Z
- ram_addr  out  ADDR_W  RAM address = pointer
- ram_cs  out  1  RAM chip select
- ram_wa  out  1  RAM write enable
- ram_oa  out  1  RAM output enable
- busy  out  1  state is WRITE, RD or CMP
- done  out  1  level, state DONE
- error  out  1  level, state ERROR
- checksum  out  DATA_W  mod-256 sum of bytes written in the current/last load
- cpu_halt  out  1  high in every state except DONE

## Operation
- States: IDLE, WRITE, RD, CMP, DONE, ERROR.
- IDLE/DONE/ERROR + start: latch last_addr, ptr←0, wr_sum←0, rd_sum←0, → WRITE.
- WRITE: ram_cs=1, ram_oa=0, in_ready=1, ram_wa=in_valid (combinational), ram_bus=in_data while ram_wa. Accept edge (in_valid&in_ready): RAM writes mem[ptr]; wr_sum+=in_data; if ptr==last_addr → RD (VERIFY=1, ptr←0) or DONE (VERIFY=0); else ptr+=1. in_valid low: no write, stay.
- RD: ram_cs=1, ram_oa=1, ram_wa=0; RAM latches mem[ptr] at this edge; → CMP.
- CMP: ram_cs=1, ram_oa=1, ram_wa=0, ram_addr unchanged; bus carries mem[ptr]. On edge: rd_sum+=ram_bus; if ptr==last_addr: → DONE if rd_sum+ram_bus==wr_sum else ERROR; else ptr+=1, → RD.
- DONE/ERROR/IDLE: ram_cs=ram_wa=ram_oa=0, bus hi-Z, in_ready=0.
- checksum = wr_sum; arithmetic mod 256, no saturation. ptr never wraps (exits at last_addr, incl. 15).
- ram_wa and ram_oa never both high.

## Timing
- Reset (async assert): in_ready=0, ram_cs/wa/oa=0, ram_bus hi-Z, ram_addr=0, busy=0, done=0, error=0, checksum=0, cpu_halt=1, state IDLE. Reset mid-load abandons the load; partial RAM contents are left as-is.
- start at edge 0: WRITE from edge 0. Continuous valid: bytes written at edges 1..N. VERIFY=1: RD/CMP for address k at edges N+1+2k / N+2+2k; done or error high after edge 3N. VERIFY=0: done high after edge N.
- Write is zero-latency: accepted byte is in RAM at the same edge.
- start while busy: ignored. abort with start on the same edge: abort wins → IDLE, done/error=0, cpu_halt=1. in_valid outside WRITE: ignored.

## Structure
- Shared package `ldr_pkg`: state enum, DATA_W/ADDR_W defaults, DEPTH=16.
- One sub-module, `ld_sum8`: clear/accumulate 8-bit modular adder, instantiated twice (wr_sum, rd_sum). FSM, pointer and tri-state bus driver stay in ram_loader.

## Test plan
- Reset mid-WRITE (rst_n low after 3 bytes) → all outputs at reset values immediately, bus hi-Z, cpu_halt=1; restart loads cleanly.
- last_addr=15, stream 0x00..0x0F with continuous valid, VERIFY=1 → RAM mem[k]=k, checksum=0x78, done high after edge 48, cpu_halt falls, no error.
- last_addr=3, bytes 0xFF,0xFF,0x02,0x01 with in_valid gaps of 2 cycles → no write during gaps, checksum=0x01 (wrap), done.
- Bench corrupts RAM model mem[2] between WRITE and CMP of addr 2 → error=1, done=0, cpu_halt stays 1; subsequent start reloads and reaches done.
- abort asserted together with start during CMP → IDLE next edge, all RAM controls low, in_ready=0.
- VERIFY=0, last_addr=0, single byte 0xA5 → mem[0]=0xA5, done after edge 1, ram_oa never asserted.

Source files
------------

// File: rtl/ldr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ldr_pkg                                                       |
// | Purpose  : Shared types and default sizes for the boot-time RAM loader.  |
// | Contents : state_t   - loader FSM state encoding                         |
// |            DATA_W_DEF, ADDR_W_DEF - default RAM word / address widths    |
// |            DEPTH     - RAM depth in words                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ldr_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_RD    = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ld_sum8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ld_sum8                                                       |
// | Purpose  : Clearable modular accumulator (sum of bytes mod 2^W).         |
// | Ports    : clk, rst_n - clock, async active-low reset                    |
// |            clr       - zero the sum (wins over acc)                      |
// |            acc       - add din into the sum on this edge                 |
// |            din       - value to add                                      |
// |            sum       - current accumulated value                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ld_sum8
  import ldr_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         acc,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_q;

  // Plain W-bit addition: carries out of the top bit are dropped (mod 2^W).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (acc) begin
      sum_q <= sum_q + din;
    end
  end

  assign sum = sum_q;

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_loader                                                    |
// | Purpose  : Boot-time program loader. Streams bytes into RAM from address |
// |            0, optionally reads the image back and compares checksums,   |
// |            and holds the CPU halted until a clean load completes.        |
// | Ports    : clk, rst_n     - clock, async active-low reset                |
// |            start, abort   - begin a load / return to IDLE (abort wins)   |
// |            last_addr      - final address of the image (N = last+1)      |
// |            in_data/valid/ready - byte stream handshake                   |
// |            ram_bus        - bidirectional RAM data bus                   |
// |            ram_addr/cs/wa/oa - RAM address and control pins              |
// |            busy, done, error - status levels                             |
// |            checksum       - mod-256 sum of bytes written this load       |
// |            cpu_halt       - low only after a clean load                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ram_loader
  import ldr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  inout  wire  [DATA_W-1:0] ram_bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_wa,
  output logic              ram_oa,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic              cpu_halt
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;

  logic              sum_clr;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] wr_sum;
  logic [DATA_W-1:0] rd_sum;
  logic [DATA_W-1:0] rd_total;
  logic              at_last;

  // Sum of write-side bytes, also the externally visible checksum.
  ld_sum8 #(.W(DATA_W)) u_wr_sum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sum_clr),
    .acc   (wr_acc),
    .din   (in_data),
    .sum   (wr_sum)
  );

  // Sum of bytes read back during the verify pass.
  ld_sum8 #(.W(DATA_W)) u_rd_sum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sum_clr),
    .acc   (rd_acc),
    .din   (ram_bus),
    .sum   (rd_sum)
  );

  // The last CMP edge must judge the sum including the byte on the bus now.
  assign rd_total = rd_sum + ram_bus;
  assign at_last  = (ptr_q == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    last_d   = last_q;
    sum_clr  = 1'b0;
    wr_acc   = 1'b0;
    rd_acc   = 1'b0;
    in_ready = 1'b0;
    ram_cs   = 1'b0;
    ram_wa   = 1'b0;
    ram_oa   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          last_d  = last_addr;
          ptr_d   = '0;
          sum_clr = 1'b1;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        ram_cs   = 1'b1;
        in_ready = 1'b1;
        // Write strobe follows in_valid directly so an accepted byte lands
        // in RAM on the same edge that the handshake completes.
        ram_wa   = in_valid;
        if (in_valid) begin
          wr_acc = 1'b1;
          if (at_last) begin
            if (VERIFY) begin
              ptr_d   = '0;
              state_d = ST_RD;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end

      ST_RD: begin
        // RAM captures mem[ptr] on this edge; data appears on the bus in CMP.
        ram_cs  = 1'b1;
        ram_oa  = 1'b1;
        state_d = ST_CMP;
      end

      ST_CMP: begin
        ram_cs = 1'b1;
        ram_oa = 1'b1;
        rd_acc = 1'b1;
        if (at_last) begin
          state_d = (rd_total == wr_sum) ? ST_DONE : ST_ERROR;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = ST_RD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides any transition, including a simultaneous start. The
    // pointer and sums are left untouched; the next start clears them.
    if (abort) begin
      state_d = ST_IDLE;
      ptr_d   = ptr_q;
      last_d  = last_q;
      sum_clr = 1'b0;
      wr_acc  = 1'b0;
      rd_acc  = 1'b0;
    end
  end

  // Bus is only ever driven during a write; otherwise the RAM (or anyone
  // else after release) owns it.
  assign ram_bus  = ram_wa ? in_data : {DATA_W{1'bz}};

  assign ram_addr = ptr_q;
  assign busy     = (state_q == ST_WRITE) || (state_q == ST_RD) || (state_q == ST_CMP);
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERROR);
  assign cpu_halt = (state_q != ST_DONE);
  assign checksum = wr_sum;

endmodule
`default_nettype wire
